// File: rtl/despertador_onchip_ram_pipe.sv
// despertador_onchip_ram_pipe: Avalon-MM on-chip RAM with byte-enabled writes,
// pipelined reads (latency 1 or 2) and an optional zero-fill sweep after reset.
module despertador_onchip_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  acc, wr_acc, rd_acc, clr_we;
  logic                  v1, v2;
  logic [DATA_WIDTH-1:0] d1, d2;
  always_comb begin
    waitrequest   = !reset_n || !clken || state == CLEAR;
    acc           = chipselect && (read || write) && !waitrequest;
    wr_acc        = acc && write;
    rd_acc        = acc && read && !write;
    clr_we        = reset_n && clken && state == CLEAR;
    readdatavalid = clken && (READ_LATENCY == 2 ? v2 : v1);
    readdata      = READ_LATENCY == 2 ? d2 : d1;
  end
  // RAM array has no reset; the clear sweep shares the single write port
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[cnt] <= '0;
    else if (wr_acc)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      d1    <= '0;
      d2    <= '0;
    end else if (clken) begin
      if (state == CLEAR) begin
        if (cnt == '1) state <= READY;
        else cnt <= cnt + 1'b1;
      end
      v1 <= rd_acc;
      if (rd_acc) d1 <= mem[address];
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  end
endmodule

// File: tb/tb_despertador_onchip_ram_pipe.sv
// tb_despertador_onchip_ram_pipe: two instances (latency 1 / 1K words, latency 2 /
// 16 words with zero-fill) checked every cycle against a timestamp-based reference.
module tb_despertador_onchip_ram_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n [2];
  logic [9:0]  address [2];
  logic [3:0]  byteenable [2];
  logic        chipselect [2], read [2], write [2], clken [2];
  logic [31:0] writedata [2];
  logic        wreq0, wreq1, rdv0, rdv1;
  logic [31:0] rdata0, rdata1;

  despertador_onchip_ram_pipe u1 (
    .clk(clk), .reset_n(reset_n[0]), .address(address[0]), .byteenable(byteenable[0]),
    .chipselect(chipselect[0]), .read(read[0]), .write(write[0]), .writedata(writedata[0]),
    .clken(clken[0]), .waitrequest(wreq0), .readdata(rdata0), .readdatavalid(rdv0));

  despertador_onchip_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u2 (
    .clk(clk), .reset_n(reset_n[1]), .address(address[1][3:0]), .byteenable(byteenable[1]),
    .chipselect(chipselect[1]), .read(read[1]), .write(write[1]), .writedata(writedata[1]),
    .clken(clken[1]), .waitrequest(wreq1), .readdata(rdata1), .readdatavalid(rdv1));

  // reference: memory image, clear words remaining, and reads due at a given clken-edge count
  typedef struct {int dut; longint due; logic [31:0] data;} pend_t;
  pend_t       pq[$];
  logic [31:0] mm [2][1024];
  int          dep [2] = '{1024, 16};
  int          lat [2] = '{1, 2};
  int          clr_left [2];
  longint      ce [2];
  logic [31:0] last [2];
  logic        s_wr [2], s_rdv [2];
  logic [31:0] s_rd [2];
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int find_due(input int i);
    for (int j = 0; j < pq.size(); j++)
      if (pq[j].dut == i && pq[j].due == ce[i]) return j;
    return -1;
  endfunction

  task automatic model_check(input int i);
    int   k;
    logic erdv;
    k = find_due(i);
    erdv = reset_n[i] && clken[i] && k >= 0;
    chk($sformatf("waitreq%0d", i), 32'(s_wr[i]), 32'(!reset_n[i] || !clken[i] || clr_left[i] > 0));
    chk($sformatf("rdvalid%0d", i), 32'(s_rdv[i]), 32'(erdv));
    if (!reset_n[i]) chk($sformatf("rd_reset%0d", i), s_rd[i], 0);
    else if (erdv) begin
      chk($sformatf("rdata%0d", i), s_rd[i], pq[k].data);
      last[i] = pq[k].data;
    end else if (k < 0) chk($sformatf("rd_hold%0d", i), s_rd[i], last[i]);
  endtask

  task automatic model_edge(input int i);
    int a;
    if (!reset_n[i]) begin
      clr_left[i] = i == 1 ? 16 : 0;
      last[i] = 0;
    end else if (clken[i]) begin
      if (clr_left[i] > 0) begin
        mm[i][dep[i] - clr_left[i]] = 0;
        clr_left[i]--;
      end else if (chipselect[i] && (read[i] || write[i])) begin
        a = int'(address[i]) % dep[i];
        if (write[i]) begin
          for (int b = 0; b < 4; b++)
            if (byteenable[i][b]) mm[i][a][8*b +: 8] = writedata[i][8*b +: 8];
        end else pq.push_back('{i, ce[i] + lat[i], mm[i][a]});
      end
      ce[i]++;
    end
    for (int j = pq.size() - 1; j >= 0; j--)
      if (pq[j].dut == i && (!reset_n[i] || pq[j].due < ce[i])) pq.delete(j);
  endtask

  task automatic tick();
    @(negedge clk);
    s_wr = '{wreq0, wreq1};
    s_rdv = '{rdv0, rdv1};
    s_rd = '{rdata0, rdata1};
    for (int i = 0; i < 2; i++) model_check(i);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    chipselect[i] = 1'b0; read[i] = 1'b0; write[i] = 1'b0;
  endtask

  task automatic wr(input int i, input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect[i] = 1'b1; read[i] = 1'b0; write[i] = 1'b1;
    address[i] = 10'(a); writedata[i] = d; byteenable[i] = be;
    tick();
    idle(i);
  endtask

  task automatic rd(input int i, input int a);
    chipselect[i] = 1'b1; read[i] = 1'b1; write[i] = 1'b0; address[i] = 10'(a);
    tick();
    idle(i);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (s_wr[1]) n++;
      else break;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0; clken[i] = 1'b1; address[i] = '0; byteenable[i] = '0;
      writedata[i] = '0; ce[i] = 0; last[i] = 0; clr_left[i] = i == 1 ? 16 : 0;
      idle(i);
      for (int a = 0; a < 1024; a++) mm[i][a] = '0;
    end
    tick(); tick();
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    wr(0, 'h005, 32'hDEADBEEF, 4'hF);
    rd(0, 'h005);
    chk("l1_no_early_valid", 32'(s_rdv[0]), 0);
    tick();
    chk("l1_valid", 32'(s_rdv[0]), 1);
    chk("l1_data", s_rd[0], 32'hDEADBEEF);

    wr(0, 'h3FF, 32'h11223344, 4'hF);
    wr(0, 'h3FF, 32'hAABBCCDD, 4'h5);
    rd(0, 'h3FF);
    tick();
    chk("byteen_merge", s_rd[0], 32'h11BB33DD);
    wr(0, 'h3FF, 32'hFFFFFFFF, 4'h0);
    rd(0, 'h3FF);
    tick();
    chk("byteen_zero", s_rd[0], 32'h11BB33DD);

    chipselect[0] = 1'b1; read[0] = 1'b1; write[0] = 1'b1;
    address[0] = 10'h010; writedata[0] = 32'h5A; byteenable[0] = 4'hF;
    tick();
    idle(0);
    tick();
    chk("rw_no_valid", 32'(s_rdv[0]), 0);
    rd(0, 'h010);
    tick();
    chk("rw_written", s_rd[0], 32'h5A);

    rd(0, 'h005);
    reset_n[0] = 1'b0;
    tick();
    reset_n[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("reset_drops_read", 32'(s_rdv[0]), 0);
    end

    for (int c = 0; c < 40 && wreq1; c++) tick();
    chk("u2_ready", 32'(wreq1), 0);
    for (int a = 0; a < 4; a++) wr(1, a, 32'(10 * (a + 1)), 4'hF);
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        chipselect[1] = 1'b1; read[1] = 1'b1; address[1] = 10'(c);
      end else idle(1);
      tick();
      chk("l2_valid", 32'(s_rdv[1]), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("l2_data", s_rd[1], 32'(10 * (c - 1)));
    end

    wr(1, 5, 32'h77, 4'hF);
    rd(1, 5);
    clken[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("frz_waitreq", 32'(s_wr[1]), 1);
      chk("frz_valid", 32'(s_rdv[1]), 0);
    end
    clken[1] = 1'b1;
    tick();
    chk("frz_first", 32'(s_rdv[1]), 0);
    tick();
    chk("frz_valid_out", 32'(s_rdv[1]), 1);
    chk("frz_data", s_rd[1], 32'h77);
    tick();
    chk("frz_once", 32'(s_rdv[1]), 0);

    for (int a = 0; a < 16; a++) wr(1, a, 32'hFFFFFFFF, 4'hF);
    reset_n[1] = 1'b0;
    tick();
    reset_n[1] = 1'b1;
    count_clear("clear_len");
    for (int a = 0; a < 16; a++) begin
      rd(1, a);
      tick();
      tick();
      chk("clear_valid", 32'(s_rdv[1]), 1);
      chk("clear_zero", s_rd[1], 0);
    end
    reset_n[1] = 1'b0;
    tick();
    reset_n[1] = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    reset_n[1] = 1'b0;
    tick();
    reset_n[1] = 1'b1;
    count_clear("clear_restart_len");

    for (int a = 0; a < 32; a++) wr(0, a, $urandom, 4'hF);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        clken[i] = $urandom_range(0, 7) != 0;
        chipselect[i] = $urandom_range(0, 3) != 0;
        read[i] = 1'($urandom);
        write[i] = 1'($urandom);
        address[i] = 10'(i == 1 ? $urandom_range(0, 15) : $urandom_range(0, 31));
        byteenable[i] = 4'($urandom);
        writedata[i] = $urandom;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      idle(i);
      clken[i] = 1'b1;
    end
    for (int c = 0; c < 4; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
